// File: rtl/seq_detect_arbiter_if.sv
// Bus bundle between the serial channel front-ends and the shared detector.
//   master: enable, ch_clear, bit_valid, bit_in out; grant/detection results in
//   slave : the detector side (inverse directions)
interface seq_detect_arbiter_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned COUNT_W = 16
);
    logic                enable;
    logic [NUM_CH-1:0]   ch_clear;
    logic [NUM_CH-1:0]   bit_valid;
    logic [NUM_CH-1:0]   bit_in;
    logic [NUM_CH-1:0]   bit_ready;
    logic                det_valid;
    logic [CH_W-1:0]     det_ch;
    logic [NUM_CH-1:0]   ctx_match;
    logic [COUNT_W-1:0]  match_total;

    modport master (
        output enable, ch_clear, bit_valid, bit_in,
        input  bit_ready, det_valid, det_ch, ctx_match, match_total
    );

    modport slave (
        input  enable, ch_clear, bit_valid, bit_in,
        output bit_ready, det_valid, det_ch, ctx_match, match_total
    );
endinterface

// File: rtl/seq_detect_arbiter.sv
// Shared overlapping "1011" Moore detector, time-multiplexed across NUM_CH
// serial channels by a round-robin arbiter with per-channel saved context.
//   clock      : system clock, rising edge
//   reset      : asynchronous active-high reset
//   bus.slave  : enable, ch_clear, bit_valid, bit_in in;
//                bit_ready (combinational grant), det_valid, det_ch,
//                ctx_match, match_total out
module seq_detect_arbiter #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    seq_detect_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S0    = 3'b000,
        S1    = 3'b001,
        S10   = 3'b011,
        S101  = 3'b010,
        S1011 = 3'b110
    } ctx_e;

    // One detector step; unused encodings recover as if in S0.
    function automatic ctx_e step(input ctx_e s, input logic b);
        ctx_e n;
        case (s)
            S0:      n = b ? S1    : S0;
            S1:      n = b ? S1    : S10;
            S10:     n = b ? S101  : S0;
            S101:    n = b ? S1011 : S10;
            S1011:   n = b ? S1    : S10;
            default: n = b ? S1    : S0;
        endcase
        return n;
    endfunction

    ctx_e               ctx_q [NUM_CH];
    ctx_e               ctx_d [NUM_CH];
    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic               det_valid_q, det_valid_d;
    logic [CH_W-1:0]    det_ch_q, det_ch_d;
    logic [COUNT_W-1:0] total_q, total_d;

    logic [NUM_CH-1:0]  elig_c;
    logic [NUM_CH-1:0]  grant_c;
    logic               found_c;
    logic [CH_W-1:0]    gidx_c;
    logic [CH_W-1:0]    cand_c;
    ctx_e               nxt_c;
    logic [NUM_CH-1:0]  match_c;

    assign elig_c = bus.bit_valid & ~bus.ch_clear & {NUM_CH{bus.enable}};

    // Round-robin search: first eligible channel at or after the pointer.
    always_comb begin
        found_c = 1'b0;
        gidx_c  = '0;
        grant_c = '0;
        cand_c  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (int'(ptr_q) + int'(k) >= int'(NUM_CH)) begin
                cand_c = CH_W'(int'(ptr_q) + int'(k) - int'(NUM_CH));
            end else begin
                cand_c = CH_W'(int'(ptr_q) + int'(k));
            end
            if (!found_c && elig_c[cand_c]) begin
                found_c = 1'b1;
                gidx_c  = cand_c;
            end
        end
        if (found_c) begin
            grant_c[gidx_c] = 1'b1;
        end
    end

    // Next-state: context update, pointer advance, detection and counter.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ctx_d[i] = bus.ch_clear[i] ? S0 : ctx_q[i];
        end
        ptr_d       = ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        total_d     = total_q;
        nxt_c       = step(ctx_q[gidx_c], bus.bit_in[gidx_c]);
        if (found_c) begin
            ctx_d[gidx_c] = nxt_c;
            ptr_d = (gidx_c == CH_W'(NUM_CH - 1)) ? '0 : gidx_c + CH_W'(1);
            if (nxt_c == S1011) begin
                det_valid_d = 1'b1;
                det_ch_d    = gidx_c;
                if (total_q != {COUNT_W{1'b1}}) begin
                    total_d = total_q + COUNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= S0;
            end
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            total_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            total_q     <= total_d;
        end
    end

    // Moore output per channel, decoded from the stored context.
    always_comb begin
        match_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            match_c[i] = (ctx_q[i] == S1011);
        end
    end

    // Grants are suppressed while reset is asserted.
    assign bus.bit_ready   = reset ? '0 : grant_c;
    assign bus.det_valid   = det_valid_q;
    assign bus.det_ch      = det_ch_q;
    assign bus.ctx_match   = match_c;
    assign bus.match_total = total_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
module tb_seq_detect_arbiter;

    logic clock;
    logic reset;

    seq_detect_arbiter_if #(.NUM_CH(4), .CH_W(2), .COUNT_W(16)) ifa ();
    seq_detect_arbiter_if #(.NUM_CH(4), .CH_W(2), .COUNT_W(2))  ifb ();

    assign ifb.enable    = ifa.enable;
    assign ifb.ch_clear  = ifa.ch_clear;
    assign ifb.bit_valid = ifa.bit_valid;
    assign ifb.bit_in    = ifa.bit_in;

    seq_detect_arbiter #(.NUM_CH(4), .CH_W(2), .COUNT_W(16)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    seq_detect_arbiter #(.NUM_CH(4), .CH_W(2), .COUNT_W(2)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each channel remembers the bits received since its
    // last clear/reset; a match means the latest four bits read 1,0,1,1.
    int m_hist [4];
    int m_cnt  [4];
    int m_ptr;
    int m_total;
    int m_det_v;
    int m_det_ch;
    int cur_grant;

    logic [3:0]  exp_ready, obs_ready;
    logic [24:0] exp_vec, obs_vec;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = 0;
            m_cnt[i]  = 0;
        end
        m_ptr = 0; m_total = 0; m_det_v = 0; m_det_ch = 0;
    endtask

    task automatic build_vecs();
        logic [3:0] em;
        for (int i = 0; i < 4; i++) em[i] = (m_cnt[i] >= 4) && (m_hist[i] == 11);
        exp_vec = {1'(m_det_v), 2'(m_det_ch), em, 16'(m_total),
                   2'((m_total > 3) ? 3 : m_total)};
        obs_vec = {ifa.det_valid, ifa.det_ch, ifa.ctx_match, ifa.match_total,
                   ifb.match_total};
    endtask

    // Drive one cycle of inputs, record grant, advance the model past the edge.
    task automatic tick(input logic en, input logic [3:0] clr,
                        input logic [3:0] val, input logic [3:0] bin);
        int c;
        ifa.enable = en; ifa.ch_clear = clr; ifa.bit_valid = val; ifa.bit_in = bin;
        #1;
        obs_ready = ifa.bit_ready;
        cur_grant = -1;
        for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (cur_grant < 0 && en && val[c] && !clr[c]) cur_grant = c;
        end
        exp_ready = '0;
        if (cur_grant >= 0) exp_ready[cur_grant] = 1'b1;
        @(posedge clock);
        #1;
        m_det_v = 0;
        for (int i = 0; i < 4; i++) begin
            if (clr[i]) begin
                m_hist[i] = 0;
                m_cnt[i]  = 0;
            end
        end
        if (cur_grant >= 0) begin
            m_hist[cur_grant] = ((m_hist[cur_grant] << 1) | int'(bin[cur_grant])) & 15;
            m_cnt[cur_grant]  = m_cnt[cur_grant] + 1;
            if (m_cnt[cur_grant] >= 4 && m_hist[cur_grant] == 11) begin
                m_det_v  = 1;
                m_det_ch = cur_grant;
                m_total  = m_total + 1;
            end
            m_ptr = (cur_grant + 1) % 4;
        end
        build_vecs();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        ifa.enable = 1'b0; ifa.ch_clear = '0; ifa.bit_valid = '0; ifa.bit_in = '0;
        #2;
        reset = 1'b0;
        #1;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifa.enable = 1'b1; ifa.ch_clear = '0; ifa.bit_valid = 4'hF; ifa.bit_in = 4'hF;
        #3;
        n_checks++;
        if (ifa.bit_ready !== 4'b0000)
            $display("FAIL reset_ready: got %b expected 0000", ifa.bit_ready);
        else n_pass++;
        model_clear();
        build_vecs();
        n_checks++;
        if (obs_vec !== exp_vec)
            $display("FAIL reset_outputs: got %h expected %h", obs_vec, exp_vec);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_single_ch0();
        logic [3:0] seq = 4'b1101;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 4'b0000, 4'b0001, {3'b000, seq[i]});
            n_checks++;
            if (obs_ready !== exp_ready || obs_vec !== exp_vec)
                $display("FAIL ch0_step%0d: got %b/%h expected %b/%h", i, obs_ready, obs_vec, exp_ready, exp_vec);
            else n_pass++;
            n_checks++;
            if (ifa.det_valid !== (i == 3))
                $display("FAIL ch0_det%0d: got %b expected %b", i, ifa.det_valid, (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (ifa.det_ch !== 2'd0 || ifa.match_total !== 16'd1 || ifa.ctx_match !== 4'b0001)
            $display("FAIL ch0_final: got ch=%0d total=%0d match=%b expected ch=0 total=1 match=0001",
                     ifa.det_ch, ifa.match_total, ifa.ctx_match);
        else n_pass++;
    endtask

    task automatic test_overlap_ch1();
        logic [6:0] seq = 7'b1101101;
        logic [6:0] det = 7'b1001000;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 4'b0000, 4'b0010, {2'b00, seq[i], 1'b0});
            n_checks++;
            if (obs_vec !== exp_vec || ifa.det_valid !== det[i])
                $display("FAIL ch1_overlap%0d: got %h expected %h (det %b)", i, obs_vec, exp_vec, det[i]);
            else n_pass++;
        end
        n_checks++;
        if (ifa.match_total !== 16'd2 || ifa.det_ch !== 2'd1)
            $display("FAIL ch1_total: got %0d/%0d expected 2/1", ifa.match_total, ifa.det_ch);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] pat = 4'b1101;
        int idx [4];
        logic [3:0] val, bin;
        apply_reset();
        for (int i = 0; i < 4; i++) idx[i] = 0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 4; i++) begin
                val[i] = (idx[i] < 4);
                bin[i] = (idx[i] < 4) ? pat[idx[i]] : 1'b0;
            end
            tick(1'b1, 4'b0000, val, bin);
            if (cur_grant >= 0) idx[cur_grant]++;
            n_checks++;
            if (obs_ready !== 4'(1 << (c % 4)) || obs_vec !== exp_vec)
                $display("FAIL rr_cycle%0d: got %b/%h expected %b/%h", c, obs_ready, obs_vec, 4'(1 << (c % 4)), exp_vec);
            else n_pass++;
            n_checks++;
            if (ifa.det_valid !== (c >= 12) || (c >= 12 && ifa.det_ch !== 2'(c - 12)))
                $display("FAIL rr_det%0d: got %b ch%0d expected %b ch%0d", c, ifa.det_valid, ifa.det_ch, (c >= 12), c - 12);
            else n_pass++;
        end
        n_checks++;
        if (ifa.match_total !== 16'd4)
            $display("FAIL rr_total: got %0d expected 4", ifa.match_total);
        else n_pass++;
    endtask

    task automatic test_clear();
        apply_reset();
        tick(1'b1, 4'b0000, 4'b0100, 4'b0100);
        tick(1'b1, 4'b0000, 4'b0100, 4'b0000);
        tick(1'b1, 4'b0000, 4'b0100, 4'b0100);
        // Clear ch2 while ch0 also requests: ch0 still gets the grant.
        tick(1'b1, 4'b0100, 4'b0101, 4'b0101);
        n_checks++;
        if (obs_ready !== 4'b0001 || obs_vec !== exp_vec)
            $display("FAIL clear_cycle: got %b/%h expected 0001/%h", obs_ready, obs_vec, exp_vec);
        else n_pass++;
        tick(1'b1, 4'b0000, 4'b0100, 4'b0100);
        n_checks++;
        if (ifa.det_valid !== 1'b0 || obs_vec !== exp_vec)
            $display("FAIL clear_nodet: got %h expected %h", obs_vec, exp_vec);
        else n_pass++;
        tick(1'b1, 4'b0000, 4'b0100, 4'b0000);
        tick(1'b1, 4'b0000, 4'b0100, 4'b0100);
        tick(1'b1, 4'b0000, 4'b0100, 4'b0100);
        n_checks++;
        if (ifa.det_valid !== 1'b1 || ifa.det_ch !== 2'd2 || obs_vec !== exp_vec)
            $display("FAIL clear_resume: got %h expected %h", obs_vec, exp_vec);
        else n_pass++;
    endtask

    task automatic test_enable();
        apply_reset();
        tick(1'b1, 4'b0000, 4'hF, 4'hF);
        tick(1'b1, 4'b0000, 4'hF, 4'hF);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 4'b0000, 4'hF, 4'hF);
            n_checks++;
            if (obs_ready !== 4'b0000 || ifa.det_valid !== 1'b0 || obs_vec !== exp_vec)
                $display("FAIL enable_off%0d: got %b/%h expected 0000/%h", c, obs_ready, obs_vec, exp_vec);
            else n_pass++;
        end
        tick(1'b1, 4'b0000, 4'hF, 4'hF);
        n_checks++;
        if (obs_ready !== 4'b0100)
            $display("FAIL enable_resume: got %b expected 0100", obs_ready);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [15:0] seq = 16'b1101101101101101;
        int ndet;
        logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        apply_reset();
        ndet = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 4'b0000, 4'b0001, {3'b000, seq[i]});
            if (ifa.det_valid === 1'b1) begin
                n_checks++;
                if (ndet > 4 || ifb.match_total !== exp_sat[ndet] || ifa.match_total !== 16'(ndet + 1))
                    $display("FAIL sat_det%0d: got %0d/%0d expected %0d/%0d", ndet, ifb.match_total,
                             ifa.match_total, exp_sat[ndet % 5], ndet + 1);
                else n_pass++;
                ndet++;
            end
        end
        n_checks++;
        if (ndet !== 5 || obs_vec !== exp_vec)
            $display("FAIL sat_count: got %0d dets %h expected 5 dets %h", ndet, obs_vec, exp_vec);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [3:0] s1 = 4'b1101;
        apply_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b0000, 4'b0010, {2'b00, s1[i], 1'b0});
        tick(1'b1, 4'b0000, 4'b0001, 4'b0001);
        tick(1'b1, 4'b0000, 4'b0001, 4'b0000);
        tick(1'b1, 4'b0000, 4'b0001, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ifa.bit_ready !== 4'b0000 || ifa.det_valid !== 1'b0 || ifa.det_ch !== 2'd0 ||
            ifa.ctx_match !== 4'b0000 || ifa.match_total !== 16'd0)
            $display("FAIL async_reset: got rdy=%b det=%b ch=%0d match=%b total=%0d expected all zero",
                     ifa.bit_ready, ifa.det_valid, ifa.det_ch, ifa.ctx_match, ifa.match_total);
        else n_pass++;
        #1;
        reset = 1'b0;
        model_clear();
        tick(1'b1, 4'b0000, 4'b0001, 4'b0001);
        n_checks++;
        if (ifa.det_valid !== 1'b0 || obs_vec !== exp_vec)
            $display("FAIL async_after: got %h expected %h", obs_vec, exp_vec);
        else n_pass++;
        tick(1'b1, 4'b0000, 4'b0001, 4'b0000);
        tick(1'b1, 4'b0000, 4'b0001, 4'b0001);
        tick(1'b1, 4'b0000, 4'b0001, 4'b0001);
        n_checks++;
        if (ifa.det_valid !== 1'b1 || obs_vec !== exp_vec)
            $display("FAIL async_resume: got %h expected %h", obs_vec, exp_vec);
        else n_pass++;
    endtask

    task automatic test_random();
        logic en;
        logic [3:0] clr;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(9) != 0);
            for (int i = 0; i < 4; i++) clr[i] = ($urandom_range(15) == 0);
            tick(en, clr, 4'($urandom), 4'($urandom));
            n_checks++;
            if (obs_ready !== exp_ready || obs_vec !== exp_vec)
                $display("FAIL random%0d: got %b/%h expected %b/%h", c, obs_ready, obs_vec, exp_ready, exp_vec);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        ifa.enable = 1'b0; ifa.ch_clear = '0; ifa.bit_valid = '0; ifa.bit_in = '0;
        test_reset();
        test_single_ch0();
        test_overlap_ch1();
        test_round_robin();
        test_clear();
        test_enable();
        test_saturation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_arbiter.md
Name: seq_detect_arbiter

Overview:
- Time-multiplexes one overlapping "1011" Moore detector engine across NUM_CH independent serial bit streams.
- Round-robin arbiter accepts at most one bit per cycle from one channel and loads that channel's saved 3-bit context.
- Applies one FSM step, writes the context back, and reports detections tagged with the channel index.
- Sits between the serial front-end channels and the event/statistics logic.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- CH_W, 2, width of channel index; must equal ceil(log2(NUM_CH)).
- COUNT_W, 16, width of saturating total-match counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  arbitration enable; low = no grants, all state holds.
- ch_clear  input  NUM_CH  per-channel synchronous context clear.
- bit_valid  input  NUM_CH  per-channel bit offered.
- bit_in  input  NUM_CH  per-channel serial bit.
- bit_ready  output  NUM_CH  one-hot grant; combinational.
- det_valid  output  1  one-cycle detection pulse.
- det_ch  output  CH_W  channel of the current detection.
- ctx_match  output  NUM_CH  per-channel Moore output: context == S1011.
- match_total  output  COUNT_W  saturating count of all detections.

Behaviour:
- Reset (async, reset=1):
  - All contexts = S0; round-robin pointer = 0.
  - det_valid=0, det_ch=0, match_total=0, ctx_match=0.
  - bit_ready forced 0 while reset is high.
- Context encoding:
  - S0=000, S1=001, S10=011, S101=010, S1011=110.
  - Any other value behaves as S0 on its next step.
- Step function (bit b):
  - S0: b ? S1 : S0
  - S1: b ? S1 : S10
  - S10: b ? S101 : S0
  - S101: b ? S1011 : S10
  - S1011: b ? S1 : S10
- Eligibility: channel i is eligible when bit_valid[i]=1, ch_clear[i]=0 and enable=1.
- Arbitration:
  - bit_ready grants the first eligible channel at or after the pointer, searching upward with wrap at NUM_CH-1 to 0.
  - At most one bit_ready bit is high; all are 0 if nothing is eligible.
  - Transfer = bit_valid[i] & bit_ready[i].
  - On a transfer from channel g, the pointer becomes (g+1) mod NUM_CH at the clock edge; with no transfer the pointer holds.
  - Requesters hold bit_in/bit_valid until granted; ready does not depend on bit_in.
- Datapath:
  - On transfer from g, ctx[g] <= step(ctx[g], bit_in[g]) at the edge; other contexts are unchanged.
- Detection, registered, latency 1:
  - If the transfer in cycle t makes the new ctx[g] == S1011, then in cycle t+1: det_valid=1, det_ch=g, and match_total increments.
  - Otherwise det_valid=0 in t+1; det_ch holds its last value.
  - ctx_match[i] is a decode of the registered context, so it rises in the same cycle as det_valid.
  - ctx_match[i] stays high until channel i's next transfer.
- match_total: increments by 1 per detection; saturates at all-ones, no wrap.
- ch_clear[i]:
  - ctx[i] <= S0 at the next edge.
  - Channel i is excluded from arbitration that cycle, so no bit is consumed and no detection is possible.
  - Clear of one channel does not disturb a grant to another.
- enable=0:
  - No grants; contexts, pointer and match_total hold; det_valid=0 the following cycle.
  - ch_clear still acts.
- Reset mid-operation: immediate return to reset values; an in-flight detection pulse is lost.

Test Plan:
- Reset, enable=1, only ch0 valid, bits 1,0,1,1 on four consecutive transfers:
  - det_valid=1 exactly once, in the cycle after the 4th transfer.
  - det_ch=0, match_total=1, ctx_match[0]=1 that cycle.
- ch1 alone, stream 1,0,1,1,0,1,1 (overlap):
  - Detections after the 4th and 7th bits; match_total=2; ch1 passes through S10 after the 5th bit.
- All four channels continuously valid, each presenting 1,0,1,1, pointer=0:
  - Grant order 0,1,2,3,0,1,...
  - After 16 cycles: detections with det_ch=0,1,2,3 on consecutive cycles, match_total=4, each context independent.
- ch2 sends 1,0,1, then ch_clear[2]=1 for one cycle while bit_valid[2]=1:
  - bit_ready[2]=0 in the clear cycle.
  - Following bit 1 yields no detection; ctx[2]=S1.
- enable=0 for 5 cycles with all channels valid:
  - bit_ready=0 throughout; contexts and pointer unchanged.
  - Sequence resumes correctly after re-enable.
- COUNT_W=2, five detections on ch0:
  - match_total counts 1,2,3,3,3.
- Async reset asserted mid-sequence (ch0 at S101) between edges:
  - Outputs clear immediately.
  - Subsequent bit 1 gives ctx[0]=S1 and no detection.
